// File: rtl/sync_fifo_flush.sv
// Single-clock FIFO with synchronous flush, threshold flags, fill level and
// sticky overflow/underflow flags. Status is decoded from registered pointers.
module sync_fifo_flush #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  clr_err,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_L    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_L    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr;
  logic [ADDR_WIDTH:0]   w_level;
  logic                  w_full, w_empty, w_wr_acc, w_rd_acc;

  // Wrap bit makes the modular difference the true occupancy, 0..DEPTH.
  assign w_level  = r_wr_ptr - r_rd_ptr;
  assign w_full   = (w_level == DEPTH_L);
  assign w_empty  = (w_level == '0);
  assign w_wr_acc = write_enable && !w_full  && !flush;
  assign w_rd_acc = read_enable  && !w_empty && !flush;

  assign level        = w_level;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (w_level >= AF_L);
  assign almost_empty = (w_level <= AE_L);

  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      read_data  <= '0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      // Flush freezes data and error flags; only the pointers and pulse reset.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      read_valid <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) begin
        r_rd_ptr  <= r_rd_ptr + 1'b1;
        read_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
      end
      read_valid <= w_rd_acc;
      // A new error event wins over a coincident clear.
      if (write_enable && w_full)     overflow <= 1'b1;
      else if (clr_err)               overflow <= 1'b0;
      if (read_enable && w_empty)     underflow <= 1'b1;
      else if (clr_err)               underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sync_fifo_flush.sv
// Bench for sync_fifo_flush: directed steps then random traffic, all outputs
// compared each cycle against a queue-based reference model.
module tb_sync_fifo_flush;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int D  = 16;
  localparam int AF = D - 2;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0, clr_err = 1'b0;
  logic          write_enable = 1'b0, read_enable = 1'b0;
  logic [DW-1:0] write_data = '0;
  logic [DW-1:0] read_data;
  logic          read_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   level;
  logic          overflow, underflow;

  sync_fifo_flush #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clk(clk), .rst(rst), .flush(flush), .clr_err(clr_err),
    .write_enable(write_enable), .write_data(write_data),
    .read_enable(read_enable), .read_data(read_data), .read_valid(read_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .level(level), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int miss = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd;
  logic          m_rv, m_ovf, m_unf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_rd = '0; m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    chk({tag, ".level"},  32'(level),        32'(n));
    chk({tag, ".full"},   32'(full),         32'(n == D));
    chk({tag, ".empty"},  32'(empty),        32'(n == 0));
    chk({tag, ".af"},     32'(almost_full),  32'(n >= AF));
    chk({tag, ".ae"},     32'(almost_empty), 32'(n <= AE));
    chk({tag, ".rv"},     32'(read_valid),   32'(m_rv));
    chk({tag, ".rdata"},  32'(read_data),    32'(m_rd));
    chk({tag, ".ovf"},    32'(overflow),     32'(m_ovf));
    chk({tag, ".unf"},    32'(underflow),    32'(m_unf));
  endtask

  // One clock: drive inputs, let the edge happen, advance model, compare.
  task automatic cyc(input string tag, input logic we, input logic [DW-1:0] wd,
                     input logic re, input logic fl, input logic ce);
    int  n;
    logic wacc, racc;
    write_enable = we; write_data = wd; read_enable = re; flush = fl; clr_err = ce;
    @(posedge clk);
    n = q.size();
    if (fl) begin
      q.delete();
      m_rv = 1'b0;
    end else begin
      wacc = we && (n < D);
      racc = re && (n > 0);
      if (racc) m_rd = q.pop_front();
      m_rv = racc;
      if (wacc) q.push_back(wd);
      if (we && n == D) m_ovf = 1'b1; else if (ce) m_ovf = 1'b0;
      if (re && n == 0) m_unf = 1'b1; else if (ce) m_unf = 1'b0;
    end
    #1;
    write_enable = 1'b0; read_enable = 1'b0; flush = 1'b0; clr_err = 1'b0;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    // Power-on reset
    rst = 1'b1;
    #12;
    check_all("por");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-stream at level 7
    for (int i = 0; i < 7; i++) cyc("pre_rst", 1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    chk("pre_rst.level7", 32'(level), 32'd7);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    chk("async_rst.empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("wr_a5", 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cyc("rd_a5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rd_a5.data", 32'(read_data), 32'hA5);
    chk("rd_a5.rv", 32'(read_valid), 32'd1);
    cyc("idle_a5", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Fill to full, overflow, drain in order
    for (int i = 0; i < D; i++) cyc("fill", 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    chk("fill.full", 32'(full), 32'd1);
    chk("fill.level16", 32'(level), 32'd16);
    cyc("ovf_wr", 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("ovf_wr.ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < D; i++) begin
      cyc("drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      chk("drain.order", 32'(read_data), 32'(i));
    end
    chk("drain.empty", 32'(empty), 32'd1);
    cyc("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Threshold walk up to 14, back to 13
    for (int i = 0; i < 14; i++) cyc("thr_up", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    chk("thr.af14", 32'(almost_full), 32'd1);
    cyc("thr_dn", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("thr.af13", 32'(almost_full), 32'd0);
    while (q.size() > 5) cyc("to5", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Concurrent at level 5, then at full
    for (int i = 0; i < 20; i++) cyc("conc5", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    chk("conc5.level", 32'(level), 32'd5);
    while (q.size() < D) cyc("to16", 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc("conc16", 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);
    chk("conc16.ovf", 32'(overflow), 32'd1);

    // Flush with coincident traffic
    while (q.size() > 0) cyc("flush_pre", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cyc("flush_wr", 1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc("flush", 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    chk("flush.level", 32'(level), 32'd0);
    chk("flush.rv", 32'(read_valid), 32'd0);
    cyc("wr_3c", 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    cyc("rd_3c", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("rd_3c.data", 32'(read_data), 32'h3C);

    // Underflow and clear
    cyc("clr0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc("unf", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    chk("unf.set", 32'(underflow), 32'd1);
    cyc("unf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("unf.clr", 32'(underflow), 32'd0);
    cyc("unf_setwins", 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("unf.setwins", 32'(underflow), 32'd1);

    // Random traffic with phases biased toward fill and drain
    for (int i = 0; i < 3000; i++) begin
      int ph, wp, rp;
      logic fl;
      ph = (i / 150) % 3;
      wp = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
      rp = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
      fl = ($urandom_range(99) < 2);
      cyc("rand", $urandom_range(99) < wp, 8'($urandom), $urandom_range(99) < rp,
          fl, !fl && ($urandom_range(99) < 5));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
